pair_scheduler: RTL and testbench

PAIR_SCHEDULER -- requirements
Module: pair_scheduler

---
 rtl/sparse_pkg.sv | 36 +++
 rtl/pair_scheduler_next_set_bit.sv | 27 ++
 rtl/pair_scheduler.sv | 175 +++++++++++++++++
 tb/tb_pair_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_pkg.sv
// Shared constants, state encoding and bit-count helpers for the sparse pair scheduler.
package sparse_pkg;

   localparam int BITMAP_W = 8;
   localparam int IDX_W    = 3;
   localparam int CNT_W    = 7;

   localparam logic [CNT_W-1:0] CNT_ZERO = 7'd0;
   localparam logic [CNT_W-1:0] CNT_ONE  = 7'd1;
   localparam logic [CNT_W-1:0] CNT_TWO  = 7'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic [IDX_W:0] popcount(input logic [BITMAP_W-1:0] bits);
      logic [IDX_W:0] cnt;
      cnt = {(IDX_W+1){1'b0}};
      for (int k = 0; k < BITMAP_W; k++) begin
         if (bits[k]) begin
            cnt = cnt + {{IDX_W{1'b0}}, 1'b1};
         end else begin
            cnt = cnt;
         end
      end
      return cnt;
   endfunction

   function automatic logic [CNT_W-1:0] pair_product(input logic [BITMAP_W-1:0] a,
                                                      input logic [BITMAP_W-1:0] b);
      return CNT_W'(popcount(a)) * CNT_W'(popcount(b));
   endfunction

endpackage

// File: rtl/pair_scheduler_next_set_bit.sv
// Finds the lowest set bit of a bitmap at or above a start index; start may be one
// past the top index, in which case nothing is found.
module next_set_bit #(
   parameter int W  = sparse_pkg::BITMAP_W,
   parameter int IW = sparse_pkg::IDX_W
) (
   input  logic [W-1:0] bitmap_i,
   input  logic [IW:0]  start_i,
   output logic [IW-1:0] pos_o,
   output logic         found_o
);

   // Priority search, scanning downward so the lowest qualifying bit wins.
   always_comb begin
      pos_o   = {IW{1'b0}};
      found_o = 1'b0;
      for (int k = W - 1; k >= 0; k--) begin
         if (bitmap_i[k] && ((IW+1)'(k) >= start_i)) begin
            pos_o   = IW'(k);
            found_o = 1'b1;
         end else begin
            found_o = found_o;
         end
      end
   end

endmodule

// File: rtl/pair_scheduler.sv
// Walks every (i,j) pair of set bits of two occupancy bitmaps in row-major order,
// one pair per accepted handshake, with a remaining-pair counter driving out_last.
module pair_scheduler #(
   parameter int BITMAP_W = sparse_pkg::BITMAP_W,
   parameter int IDX_W    = sparse_pkg::IDX_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [BITMAP_W-1:0]          in_comp1,
   input  logic [BITMAP_W-1:0]          in_comp2,
   input  logic                         flush,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [BITMAP_W-1:0]          out_comp1,
   output logic [BITMAP_W-1:0]          out_comp2,
   output logic [IDX_W-1:0]             out_i,
   output logic [IDX_W-1:0]             out_j,
   output logic                         out_last,
   output logic                         done,
   output logic [sparse_pkg::CNT_W-1:0] pair_count
);

   import sparse_pkg::*;

   state_e                state_q, state_d;
   logic [BITMAP_W-1:0]   comp1_q, comp1_d;
   logic [BITMAP_W-1:0]   comp2_q, comp2_d;
   logic [IDX_W-1:0]      i_q, i_d;
   logic [IDX_W-1:0]      j_q, j_d;
   logic [IDX_W-1:0]      jmin_q, jmin_d;
   logic [CNT_W-1:0]      rem_q, rem_d;
   logic [CNT_W-1:0]      pc_q, pc_d;
   logic                  last_q, last_d;

   logic [BITMAP_W-1:0]   map1_s, map2_s;
   logic [IDX_W:0]        start1_s, start2_s;
   logic [IDX_W-1:0]      pos1_s, pos2_s;
   logic                  found1_s, found2_s;
   logic [CNT_W-1:0]      pc_s;

   assign pc_s = pair_product(in_comp1, in_comp2);

   // In IDLE the searchers look at the offered bitmaps from bit 0; in SCAN they look
   // just above the current row/column of the latched bitmaps.
   always_comb begin
      if (state_q == ST_IDLE) begin
         map1_s   = in_comp1;
         map2_s   = in_comp2;
         start1_s = {(IDX_W+1){1'b0}};
         start2_s = {(IDX_W+1){1'b0}};
      end else begin
         map1_s   = comp1_q;
         map2_s   = comp2_q;
         start1_s = {1'b0, i_q} + {{IDX_W{1'b0}}, 1'b1};
         start2_s = {1'b0, j_q} + {{IDX_W{1'b0}}, 1'b1};
      end
   end

   next_set_bit #(.W(BITMAP_W), .IW(IDX_W)) u_nsb_row (
      .bitmap_i (map1_s),
      .start_i  (start1_s),
      .pos_o    (pos1_s),
      .found_o  (found1_s)
   );

   next_set_bit #(.W(BITMAP_W), .IW(IDX_W)) u_nsb_col (
      .bitmap_i (map2_s),
      .start_i  (start2_s),
      .pos_o    (pos2_s),
      .found_o  (found2_s)
   );

   // Next-state logic; flush overrides every handshake.
   always_comb begin
      state_d = state_q;
      comp1_d = comp1_q;
      comp2_d = comp2_q;
      i_d     = i_q;
      j_d     = j_q;
      jmin_d  = jmin_q;
      rem_d   = rem_q;
      pc_d    = pc_q;
      last_d  = last_q;
      if (flush) begin
         state_d = ST_IDLE;
         last_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  comp1_d = in_comp1;
                  comp2_d = in_comp2;
                  pc_d    = pc_s;
                  rem_d   = pc_s;
                  i_d     = pos1_s;
                  j_d     = pos2_s;
                  jmin_d  = pos2_s;
                  last_d  = (pc_s == CNT_ONE);
                  if (found1_s && found2_s) begin
                     state_d = ST_SCAN;
                  end else begin
                     state_d = ST_DONE;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_SCAN: begin
               if (out_ready) begin
                  if (last_q) begin
                     state_d = ST_DONE;
                     last_d  = 1'b0;
                  end else begin
                     rem_d  = rem_q - CNT_ONE;
                     last_d = (rem_q == CNT_TWO);
                     // Column exhausted: wrap to the first column and step the row.
                     if (found2_s) begin
                        j_d = pos2_s;
                     end else begin
                        j_d = jmin_q;
                        i_d = pos1_s;
                     end
                  end
               end else begin
                  state_d = ST_SCAN;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and job registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         comp1_q <= {BITMAP_W{1'b0}};
         comp2_q <= {BITMAP_W{1'b0}};
         i_q     <= {IDX_W{1'b0}};
         j_q     <= {IDX_W{1'b0}};
         jmin_q  <= {IDX_W{1'b0}};
         rem_q   <= CNT_ZERO;
         pc_q    <= CNT_ZERO;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         comp1_q <= comp1_d;
         comp2_q <= comp2_d;
         i_q     <= i_d;
         j_q     <= j_d;
         jmin_q  <= jmin_d;
         rem_q   <= rem_d;
         pc_q    <= pc_d;
         last_q  <= last_d;
      end
   end

   assign in_ready   = (state_q == ST_IDLE);
   assign out_valid  = (state_q == ST_SCAN);
   assign done       = (state_q == ST_DONE);
   assign out_last   = last_q;
   assign out_i      = i_q;
   assign out_j      = j_q;
   assign out_comp1  = comp1_q;
   assign out_comp2  = comp2_q;
   assign pair_count = pc_q;

endmodule

// File: tb/tb_pair_scheduler.sv
// Directed bench: a reference pair list is queued per job and popped on every handshake.
module tb_pair_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, flush, out_valid, out_ready, out_last, done;
   logic [7:0] in_comp1, in_comp2, out_comp1, out_comp2;
   logic [2:0] out_i, out_j;
   logic [6:0] pair_count;

   typedef struct packed {
      logic [2:0] i;
      logic [2:0] j;
      logic       last;
   } pair_t;

   pair_t exp_q[$];
   int    checks = 0;
   int    errors = 0;

   pair_scheduler dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_comp1   (in_comp1),
      .in_comp2   (in_comp2),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_comp1  (out_comp1),
      .out_comp2  (out_comp2),
      .out_i      (out_i),
      .out_j      (out_j),
      .out_last   (out_last),
      .done       (done),
      .pair_count (pair_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic build_model(input logic [7:0] c1, input logic [7:0] c2, output logic [6:0] pc);
      pair_t p;
      int    n1, n2;
      n1 = 0;
      n2 = 0;
      exp_q.delete();
      for (int k = 0; k < 8; k++) begin
         n1 += int'(c1[k]);
         n2 += int'(c2[k]);
      end
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            if (c1[i] && c2[j]) begin
               p.i = 3'(i);
               p.j = 3'(j);
               p.last = 1'b0;
               exp_q.push_back(p);
            end
         end
      end
      if (exp_q.size() > 0) begin
         p = exp_q.pop_back();
         p.last = 1'b1;
         exp_q.push_back(p);
      end
      pc = 7'(n1 * n2);
   endtask

   task automatic run_job(input logic [7:0] c1, input logic [7:0] c2, input bit stalls,
                          input int abort_at, input bit abort_rst);
      logic [6:0] pc;
      pair_t      e, held;
      int         hs;
      bit         fin, stalled, expect_done;
      hs = 0;
      fin = 1'b0;
      stalled = 1'b0;
      expect_done = 1'b0;
      held = '0;
      build_model(c1, c2, pc);
      @(negedge clk);
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_comp1 = c1;
      in_comp2 = c2;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      in_comp1 = 8'($urandom);
      in_comp2 = 8'($urandom);
      chk("pair_count", 32'(pair_count), 32'(pc));
      chk("latched_comp1", 32'(out_comp1), 32'(c1));
      chk("latched_comp2", 32'(out_comp2), 32'(c2));
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      chk("first_valid_latency", 32'(out_valid), 32'(pc != 7'd0));
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
         if (expect_done) chk("done_after_last", 32'(done), 32'd1);
         if (done) begin
            chk("queue_drained", 32'(exp_q.size()), 32'd0);
            chk("no_valid_in_done", 32'(out_valid), 32'd0);
            in_valid = 1'b0;
            out_ready = 1'b0;
            fin = 1'b1;
         end else if (out_valid) begin
            chk("comp1_held", 32'(out_comp1), 32'(c1));
            chk("comp2_held", 32'(out_comp2), 32'(c2));
            if (stalled) begin
               chk("stall_i", 32'(out_i), 32'(held.i));
               chk("stall_j", 32'(out_j), 32'(held.j));
               chk("stall_last", 32'(out_last), 32'(held.last));
            end
            if (hs == abort_at) begin
               if (abort_rst) begin
                  rst = 1'b0;
                  #1;
                  chk("rst_out_valid", 32'(out_valid), 32'd0);
                  chk("rst_in_ready", 32'(in_ready), 32'd1);
                  chk("rst_pair_count", 32'(pair_count), 32'd0);
                  chk("rst_comp1", 32'(out_comp1), 32'd0);
                  chk("rst_i_j_last", 32'({out_i, out_j, out_last, done}), 32'd0);
                  @(negedge clk);
                  rst = 1'b1;
               end else begin
                  flush = 1'b1;
                  out_ready = 1'b1;
                  @(negedge clk);
                  flush = 1'b0;
                  chk("flush_out_valid", 32'(out_valid), 32'd0);
                  chk("flush_in_ready", 32'(in_ready), 32'd1);
                  chk("flush_no_done", 32'(done), 32'd0);
               end
               @(negedge clk);
               chk("abort_no_done", 32'(done), 32'd0);
               chk("abort_idle", 32'(in_ready), 32'd1);
               exp_q.delete();
               fin = 1'b1;
            end else begin
               out_ready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
               in_valid = stalls ? 1'($urandom_range(0, 1)) : 1'b0;
               held.i = out_i;
               held.j = out_j;
               held.last = out_last;
               if (out_ready) begin
                  if (exp_q.size() == 0) begin
                     chk("extra_pair", 32'd1, 32'd0);
                  end else begin
                     e = exp_q.pop_front();
                     chk("pair_i", 32'(out_i), 32'(e.i));
                     chk("pair_j", 32'(out_j), 32'(e.j));
                     chk("pair_last", 32'(out_last), 32'(e.last));
                     expect_done = e.last;
                  end
                  if (c1 == 8'hF9 && c2 == 8'h6F && hs == 21)
                     chk("handshake22_is_5_3", 32'({out_i, out_j}), 32'({3'd5, 3'd3}));
                  hs++;
                  stalled = 1'b0;
               end else begin
                  stalled = 1'b1;
               end
            end
         end else begin
            chk("no_bubble", 32'(out_valid), 32'd1);
            fin = 1'b1;
         end
         if (!fin) @(negedge clk);
      end
      if (!fin) chk("job_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      out_ready = 1'b0;
      if (abort_at < 0) begin
         @(negedge clk);
         chk("done_one_cycle", 32'(done), 32'd0);
         chk("back_to_idle", 32'(in_ready), 32'd1);
      end
   endtask

   initial begin
      rst = 1'b0;
      in_valid = 1'b0;
      in_comp1 = 8'd0;
      in_comp2 = 8'd0;
      flush = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_last_done", 32'({out_last, done}), 32'd0);
      chk("reset_ij", 32'({out_i, out_j}), 32'd0);
      chk("reset_comps", 32'({out_comp1, out_comp2}), 32'd0);
      chk("reset_pair_count", 32'(pair_count), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      run_job(8'b11111001, 8'b01101111, 1'b0, -1, 1'b0);
      chk("pair_count_36", 32'(pair_count), 32'd36);
      run_job(8'b00000000, 8'hFF, 1'b0, -1, 1'b0);
      chk("pair_count_zero", 32'(pair_count), 32'd0);
      run_job(8'b00010000, 8'b10000000, 1'b0, -1, 1'b0);
      run_job(8'b11111001, 8'b01101111, 1'b1, -1, 1'b0);
      run_job(8'b11111001, 8'b01101111, 1'b0, 9, 1'b0);
      run_job(8'b11111001, 8'b01101111, 1'b0, -1, 1'b0);
      run_job(8'b11111001, 8'b01101111, 1'b0, 12, 1'b1);
      run_job(8'b11111001, 8'b01101111, 1'b0, -1, 1'b0);
      run_job(8'b10100110, 8'b00011001, 1'b1, -1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
